// File: rtl/branch_resolve_unit_if.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit_if
//   Bundles the prediction push channel, the EX resolve channel and the
//   flush/statistics outputs of branch_resolve_unit.
//   master : drives push_* and resolve_*, observes everything else (IF/EX side)
//   slave  : the branch_resolve_unit itself
// ---------------------------------------------------------------------------
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  // prediction push channel (from IF)
  logic             push_valid;
  logic [XLEN-1:0]  push_pc;
  logic             push_pred_taken;
  logic [XLEN-1:0]  push_pred_target;
  logic             push_ready;
  // resolve channel (from EX)
  logic             resolve_valid;
  logic             resolve_taken;
  logic [XLEN-1:0]  resolve_target;
  // flush request back to the predictor, status and statistics
  logic             flush_flag;
  logic [XLEN-1:0]  flush_addr;
  logic             fifo_empty;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;
  logic             order_err;

  modport master (
    output push_valid, push_pc, push_pred_taken, push_pred_target,
    output resolve_valid, resolve_taken, resolve_target,
    input  push_ready, flush_flag, flush_addr, fifo_empty,
    input  branch_cnt, mispredict_cnt, order_err
  );

  modport slave (
    input  push_valid, push_pc, push_pred_taken, push_pred_target,
    input  resolve_valid, resolve_taken, resolve_target,
    output push_ready, flush_flag, flush_addr, fifo_empty,
    output branch_cnt, mispredict_cnt, order_err
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//   Execute-side checker for the fetch-stage static branch predictor.
//   Each prediction issued by IF is queued in an in-order FIFO. When EX
//   resolves the oldest control transfer, it is compared with the head entry;
//   a mismatch clears the FIFO (all younger entries are wrong-path) and raises
//   a one-cycle registered flush_flag with the correct refetch address.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - branch_resolve_unit_if.slave:
//            push_valid/pc/pred_taken/pred_target, push_ready  (IF side)
//            resolve_valid/taken/target                        (EX side)
//            flush_flag, flush_addr                            (to predictor)
//            fifo_empty, branch_cnt, mispredict_cnt, order_err (status)
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resolve_unit_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   ONE_CNT  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  INSN_SZ  = XLEN'(4);

  // FIFO storage (small, read combinationally so the head is compared in
  // the same cycle the resolve arrives)
  logic [XLEN-1:0] pc_mem     [DEPTH];
  logic            taken_mem  [DEPTH];
  logic [XLEN-1:0] target_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             flush_flag_q, flush_flag_d;
  logic [XLEN-1:0]  flush_addr_q, flush_addr_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;
  logic             order_err_q, order_err_d;

  logic            empty;
  logic            full;
  logic            do_pop;
  logic            do_push;
  logic            mispredict;
  logic            mem_wr_en;
  logic [XLEN-1:0] head_pc;
  logic            head_taken;
  logic [XLEN-1:0] head_target;
  logic [XLEN-1:0] correct_addr;

  assign empty       = (count_q == '0);
  assign full        = (count_q == FULL_CNT);
  assign head_pc     = pc_mem[rd_ptr_q];
  assign head_taken  = taken_mem[rd_ptr_q];
  assign head_target = target_mem[rd_ptr_q];

  always_comb begin
    do_pop       = bus.resolve_valid && !empty;
    mispredict   = do_pop &&
                   ((bus.resolve_taken != head_taken) ||
                    (bus.resolve_taken && (bus.resolve_target != head_target)));
    correct_addr = bus.resolve_taken ? bus.resolve_target : (head_pc + INSN_SZ);
    // A correct pop frees a slot in the same edge, so a push is still taken
    // while full. A push alongside a mispredict is wrong-path and dropped.
    do_push      = bus.push_valid && (!full || (do_pop && !mispredict)) && !mispredict;
    mem_wr_en    = do_push;

    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    flush_flag_d     = mispredict;
    flush_addr_d     = flush_addr_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    order_err_d      = order_err_q | (bus.resolve_valid && empty);

    if (do_pop && (branch_cnt_q != CNT_MAX)) begin
      branch_cnt_d = branch_cnt_q + CNT_ONE;
    end

    if (mispredict) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      flush_addr_d = correct_addr;
      if (mispredict_cnt_q != CNT_MAX) begin
        mispredict_cnt_d = mispredict_cnt_q + CNT_ONE;
      end
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + ONE_PTR;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + ONE_PTR;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + ONE_CNT;
        2'b01:   count_d = count_q - ONE_CNT;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      flush_flag_q     <= 1'b0;
      flush_addr_q     <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      order_err_q      <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      flush_flag_q     <= flush_flag_d;
      flush_addr_q     <= flush_addr_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      order_err_q      <= order_err_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      pc_mem[wr_ptr_q]     <= bus.push_pc;
      taken_mem[wr_ptr_q]  <= bus.push_pred_taken;
      target_mem[wr_ptr_q] <= bus.push_pred_target;
    end
  end

  assign bus.push_ready     = (count_q != FULL_CNT);
  assign bus.fifo_empty     = empty;
  assign bus.flush_flag     = flush_flag_q;
  assign bus.flush_addr     = flush_addr_q;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;
  assign bus.order_err      = order_err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//   Directed scenarios followed by randomized push/resolve traffic, all
//   checked against a queue-based reference model of the prediction FIFO.
//   Counters are built narrow (6 bits) so saturation is reached in the run.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } ent_t;

  // reference model state
  ent_t        q[$];
  logic        m_flush;
  logic [31:0] m_addr;
  int          m_bcnt;
  int          m_mcnt;
  logic        m_oerr;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (txn %0d)", tag, got, exp, n_txn);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_flush = 1'b0;
    m_addr  = '0;
    m_bcnt  = 0;
    m_mcnt  = 0;
    m_oerr  = 1'b0;
  endtask

  task automatic check_all();
    check_val("flush_flag", 64'(bus.flush_flag), 64'(m_flush));
    check_val("flush_addr", 64'(bus.flush_addr), 64'(m_addr));
    check_val("fifo_empty", 64'(bus.fifo_empty), 64'(q.size() == 0));
    check_val("push_ready", 64'(bus.push_ready), 64'(q.size() != DEPTH));
    check_val("branch_cnt", 64'(bus.branch_cnt), 64'(m_bcnt));
    check_val("mispredict_cnt", 64'(bus.mispredict_cnt), 64'(m_mcnt));
    check_val("order_err", 64'(bus.order_err), 64'(m_oerr));
  endtask

  // One clock of stimulus: drive, let the edge happen, advance the model,
  // compare everything the DUT exposes.
  task automatic step(input logic pv, input logic [31:0] pc, input logic pt,
                      input logic [31:0] ptg, input logic rv, input logic rt,
                      input logic [31:0] rtg);
    ent_t h;
    ent_t e;
    logic pop;
    logic mis;
    logic push_ok;
    bus.push_valid       = pv;
    bus.push_pc          = pc;
    bus.push_pred_taken  = pt;
    bus.push_pred_target = ptg;
    bus.resolve_valid    = rv;
    bus.resolve_taken    = rt;
    bus.resolve_target   = rtg;

    pop = rv && (q.size() > 0);
    mis = 1'b0;
    if (pop) begin
      h   = q[0];
      mis = (rt != h.pt) || (rt && (rtg != h.tgt));
    end
    push_ok = pv && !mis && ((q.size() < DEPTH) || pop);
    if (rv && q.size() == 0) m_oerr = 1'b1;

    @(posedge clk);
    #1;
    n_txn++;
    m_flush = mis;
    if (pop && m_bcnt != CMAX) m_bcnt++;
    if (mis) begin
      m_addr = rt ? rtg : (h.pc + 32'd4);
      if (m_mcnt != CMAX) m_mcnt++;
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push_ok) begin
        e.pc = pc; e.pt = pt; e.tgt = ptg;
        q.push_back(e);
      end
    end
    $display("txn %0d: push=%0d pc=%h pt=%0d tgt=%h | res=%0d t=%0d tgt=%h | flush=%0d addr=%h cnt=%0d",
             n_txn, pv, pc, pt, ptg, rv, rt, rtg, bus.flush_flag, bus.flush_addr, q.size());
    check_all();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    step(1'b1, pc, pt, tgt, 1'b0, 1'b0, '0);
  endtask

  task automatic resolve(input logic rt, input logic [31:0] tgt);
    step(1'b0, '0, 1'b0, '0, 1'b1, rt, tgt);
  endtask

  initial begin
    bus.push_valid = 1'b0; bus.push_pc = '0; bus.push_pred_taken = 1'b0;
    bus.push_pred_target = '0; bus.resolve_valid = 1'b0; bus.resolve_taken = 1'b0;
    bus.resolve_target = '0;
    model_reset();
    #1;
    check_all();  // reset state while rst is held
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // correct prediction
    push(32'h100, 1'b1, 32'h80);
    resolve(1'b1, 32'h80);
    check_val("tp1_branch_cnt", 64'(bus.branch_cnt), 64'd1);
    check_val("tp1_flush", 64'(bus.flush_flag), 64'd0);

    // direction mispredict
    push(32'h200, 1'b1, 32'h1F0);
    resolve(1'b0, 32'h0);
    check_val("tp2_flush_addr", 64'(bus.flush_addr), 64'h204);
    idle();
    check_val("tp2_pulse_end", 64'(bus.flush_flag), 64'd0);

    // target mispredict discards younger wrong-path entries
    push(32'h10, 1'b1, 32'h40);
    push(32'h20, 1'b1, 32'h40);
    push(32'h30, 1'b1, 32'h40);
    resolve(1'b1, 32'h44);
    check_val("tp3_flush_addr", 64'(bus.flush_addr), 64'h44);
    resolve(1'b1, 32'h40);
    check_val("tp3_order_err", 64'(bus.order_err), 64'd1);

    // full, dropped push, simultaneous push+pop
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i * 4), 1'b0, 32'h0);
    check_val("tp4_ready_full", 64'(bus.push_ready), 64'd0);
    push(32'h2000, 1'b1, 32'h3000);              // dropped
    step(1'b1, 32'h1010, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);  // pop 0x1000, push at tail
    for (int i = 0; i < DEPTH - 1; i++) resolve(1'b0, 32'h0);
    step(1'b1, 32'h5000, 1'b1, 32'h6000, 1'b1, 1'b1, 32'h7000);  // 0x1010 mispredicted
    check_val("tp4_flush_addr", 64'(bus.flush_addr), 64'h7000);
    check_val("tp4_empty", 64'(bus.fifo_empty), 64'd1);

    // address wrap and pointer wrap
    push(32'hFFFF_FFFC, 1'b1, 32'h100);
    resolve(1'b0, 32'h0);
    check_val("tp5_wrap_addr", 64'(bus.flush_addr), 64'h0);
    push(32'h400, 1'b0, 32'h0);  // accepted while flush_flag=1
    for (int i = 1; i <= 3 * DEPTH; i++)
      step(1'b1, 32'h400 + 32'(i * 4), 1'(i % 2), 32'h800 + 32'(i * 8),
           1'b1, 1'((i - 1) % 2), 32'h800 + 32'((i - 1) * 8));
    resolve(1'b1, 32'h0);  // head (i=12, not taken) mispredicts
    check_val("tp5_order_addr", 64'(bus.flush_addr), 64'h0);

    // reset while flush pulse is up
    push(32'h300, 1'b1, 32'h500);
    resolve(1'b0, 32'h0);
    check_val("tp6_flush_up", 64'(bus.flush_flag), 64'd1);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic        pv, pt, rv, rt;
      logic [31:0] pc, ptg, rtg;
      pv  = ($urandom_range(0, 99) < 55);
      pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
      pt  = 1'($urandom);
      ptg = $urandom_range(0, 1) ? 32'h40 : 32'h80;
      rv  = ($urandom_range(0, 99) < 45);
      rt  = 1'($urandom);
      rtg = $urandom_range(0, 1) ? 32'h40 : 32'h80;
      if (q.size() > 0 && $urandom_range(0, 99) < 75) begin
        rt  = q[0].pt;
        rtg = q[0].tgt;
      end
      step(pv, pc, pt, ptg, rv, rt, rtg);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-side counterpart of the fetch-stage static branch predictor.
- Records each control-transfer prediction issued by IF in an in-order FIFO, then compares the oldest entry against the actual outcome when EX resolves it.
- On a misprediction, produces the registered flush_flag/flush_addr pair consumed by the predictor, discards all younger wrong-path entries, and keeps branch/mispredict statistics.

Parameters:
XLEN, 32, address/data width
DEPTH, 4, in-flight prediction FIFO entries (power of two, >=2)
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
push_valid  in  1  IF issues a JAL/branch prediction this cycle
push_pc  in  XLEN  PC of that instruction
push_pred_taken  in  1  predictor chose taken
push_pred_target  in  XLEN  predicted next PC
push_ready  out  1  FIFO not full
resolve_valid  in  1  EX resolves oldest in-flight control transfer
resolve_taken  in  1  actual direction
resolve_target  in  XLEN  actual taken target
flush_flag  out  1  one-cycle flush request to predictor
flush_addr  out  XLEN  refetch address, valid while flush_flag=1
fifo_empty  out  1  no entries in flight
branch_cnt  out  CNT_W  resolved control transfers
mispredict_cnt  out  CNT_W  mispredictions
order_err  out  1  sticky: resolve_valid seen with FIFO empty

Behaviour:
- Reset (async, rst=1): read/write pointers and count=0, flush_flag=0, flush_addr=0, branch_cnt=0, mispredict_cnt=0, order_err=0, fifo_empty=1, push_ready=1.
- Push: entry {pc, pred_taken, pred_target} is written on the clk edge when push_valid && push_ready. push_valid while full is dropped; no state change occurs.
- push_ready = (count != DEPTH), combinational from count.
- Resolve: when resolve_valid && !fifo_empty, the head entry H is popped on the clk edge.
- Misprediction condition: (resolve_taken != H.pred_taken) || (resolve_taken && resolve_target != H.pred_target).
- Correct address: resolve_taken ? resolve_target : H.pc + 4. Arithmetic is modulo 2^XLEN, so all-ones+4 wraps.
- On mispredict at edge N:
  - FIFO is cleared (pointers and count=0).
  - flush_flag=1 and flush_addr=correct address are registered, visible cycle N+1.
  - mispredict_cnt increments.
- flush_flag is a single-cycle pulse. It returns to 0 at edge N+1 unless another mispredict is resolved there. flush_addr holds its last value when flush_flag=0.
- branch_cnt increments on every successful pop. Both counters saturate at all-ones; they do not wrap.
- Simultaneous push and resolve, correct prediction: pop and push both occur; count is unchanged. This is legal when full.
- Simultaneous push and resolve, mispredict: the pushed entry is wrong-path and is discarded. FIFO ends empty.
- Push in a cycle where flush_flag=1: accepted. The entry belongs to the new path fetched at flush_addr.
- Resolve with FIFO empty: ignored for the counters and flush; order_err is set and stays set until reset.
- Latency: outcome-to-flush is exactly 1 cycle; push-to-poppable is 1 cycle.
- Reset asserted mid-operation immediately clears everything, including a pending flush pulse.

Test Plan:
- Correct prediction: push pc=0x100, taken=1, target=0x80; next cycle resolve taken=1, target=0x80 -> flush_flag stays 0, branch_cnt=1, mispredict_cnt=0, fifo_empty=1.
- Direction mispredict: push pc=0x200, taken=1, target=0x1F0; resolve taken=0 -> one cycle later flush_flag=1 for exactly 1 cycle, flush_addr=0x204, mispredict_cnt=1.
- Target mispredict with wrong-path flush: push 3 entries (pc 0x10, 0x20, 0x30, all predicted taken to 0x40); resolve first with taken=1, target=0x44 -> flush_addr=0x44, FIFO empty, the other 2 entries discarded, and a subsequent resolve sets order_err=1.
- Full/simultaneous: fill DEPTH=4 entries, so push_ready=0; a push while full is dropped and count stays 4. Push and resolve-correct in the same cycle -> count stays 4 and the new entry lands at the tail. Push and resolve-mispredict in the same cycle -> fifo_empty=1.
- Wrap-around: push pc=0xFFFFFFFC, predicted taken; resolve not-taken -> flush_addr=0x00000000. Run more than 2*DEPTH push/pop pairs to confirm pointer wrap preserves order.
- Reset mid-flush: assert rst in the cycle flush_flag=1 -> flush_flag=0, counters=0, fifo_empty=1 immediately, without waiting for a clock edge.
